// File: rtl/ceres_pkg.sv
// ceres_pkg: shared types and constants for the ceres memory hierarchy.
//
// Contents:
//   XLEN, BLK_SIZE   address width and cache block width in bits
//   lowX_req_t       request on a lower-level memory port (cache -> memory)
//   lowX_res_t       response on a lower-level memory port (memory -> cache)
//   arb_state_e      state encoding of the lowX memory arbiter
//   ARB_ICACHE/ARB_DCACHE  requester identifiers used by the arbiter
package ceres_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;

  typedef struct packed {
    logic                valid;
    logic                ready;     // requester can take a response
    logic [XLEN-1:0]     addr;
    logic [1:0]          rw_size;
    logic                rw;        // 1 = write
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowX_res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic ARB_ICACHE = 1'b0;
  localparam logic ARB_DCACHE = 1'b1;

endpackage

// File: rtl/lowx_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant with a priority pointer.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i[1:0]     request vector, bit ARB_ICACHE / bit ARB_DCACHE
//   en_i           grant allowed this cycle
//   upd_i          move the pointer away from last_i (end of a transaction)
//   last_i         requester that just finished
//   gnt_valid_o    a grant is issued this cycle
//   gnt_idx_o      index of the granted requester
module rr_arbiter2
  import ceres_pkg::*;
#(
  parameter bit RESET_PRIO = ARB_DCACHE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       upd_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // prio_q names the requester that wins when both ask at once.
  logic prio_q;
  logic prio_d;

  always_comb begin
    prio_d = prio_q;
    if (upd_i) begin
      prio_d = ~last_i;
    end
  end

  always_comb begin
    gnt_valid_o = en_i && (req_i != 2'b00);
    gnt_idx_o   = (req_i == 2'b11) ? prio_q : req_i[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= RESET_PRIO;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/lowx_mem_arbiter.sv
// lowx_mem_arbiter: shares one lower-level memory port between the icache
// and dcache. A round-robin winner is granted in IDLE (its res.ready pulses
// in the same cycle), its request is latched and presented to memory in
// ISSUE, the memory return is captured in WAIT (or ISSUE when ready and
// valid coincide), and RESP hands the captured block to the owner only.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   icache_req_i    icache lowX request     icache_res_o  response to icache
//   dcache_req_i    dcache lowX request     dcache_res_o  response to dcache
//   mem_req_o       request to memory       mem_res_i     memory response
//   busy_o          transaction in progress
//   owner_o         current/last owner (0 icache, 1 dcache)
module lowx_mem_arbiter
  import ceres_pkg::*;
#(
  parameter int unsigned XLEN         = ceres_pkg::XLEN,
  parameter int unsigned BLK_SIZE     = ceres_pkg::BLK_SIZE,
  parameter bit          DCACHE_FIRST = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  lowX_req_t icache_req_i,
  output lowX_res_t icache_res_o,
  input  lowX_req_t dcache_req_i,
  output lowX_res_t dcache_res_o,
  output lowX_req_t mem_req_o,
  input  lowX_res_t mem_res_i,
  output logic      busy_o,
  output logic      owner_o
);

  // The port structs are sized by the package; the parameters must agree.
  localparam bit PARAMS_OK = (XLEN == ceres_pkg::XLEN) && (BLK_SIZE == ceres_pkg::BLK_SIZE);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  lowX_req_t           req_q, req_d;
  logic [BLK_SIZE-1:0] rdata_q, rdata_d;

  logic gnt_valid;
  logic gnt_idx;

  rr_arbiter2 #(
    .RESET_PRIO (DCACHE_FIRST)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       ({dcache_req_i.valid, icache_req_i.valid}),
    .en_i        (state_q == IDLE),
    .upd_i       (state_q == RESP),
    .last_i      (owner_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    icache_res_o = '0;
    dcache_res_o = '0;
    mem_req_o    = '0;

    unique case (state_q)
      IDLE: begin
        // The ready pulse is combinational on the live request so the
        // requester sees acceptance in the very cycle it is granted.
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = ISSUE;
          if (gnt_idx == ARB_DCACHE) begin
            req_d              = dcache_req_i;
            dcache_res_o.ready = 1'b1;
          end else begin
            req_d              = icache_req_i;
            icache_res_o.ready = 1'b1;
          end
        end
      end

      ISSUE: begin
        mem_req_o       = req_q;
        mem_req_o.valid = 1'b1;
        if (mem_res_i.ready) begin
          if (mem_res_i.valid) begin
            rdata_d = mem_res_i.data;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (mem_res_i.valid) begin
          rdata_d = mem_res_i.data;
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_q == ARB_DCACHE) begin
          dcache_res_o.valid = 1'b1;
          dcache_res_o.data  = rdata_q;
        end else begin
          icache_res_o.valid = 1'b1;
          icache_res_o.data  = rdata_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= DCACHE_FIRST;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

  // Memory data only has meaning while a request is outstanding.
  a_mem_valid_window: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_res_i.valid |-> (state_q == ISSUE || state_q == WAIT));

  a_params_match: assert property (@(posedge clk_i) PARAMS_OK);

endmodule
